// File: rtl/sonata_input_conditioner.sv
// sonata_input_conditioner
// Conditions raw board inputs (joystick, switches, card detect) for the GPIO block.
// Each channel passes through a synchroniser, polarity correction, a debounce filter,
// edge-pulse generation and a sticky edge-pending flag.
// Optional feature macro: SONATA_INPUT_IRQ_EN adds irq_en_i / irq_o (level interrupt).
module sonata_input_conditioner #(
  parameter int                NumCh      = 16,
  parameter int                SyncStages = 2,
  parameter int                DebounceW  = 20,
  parameter logic [NumCh-1:0]  InvertMask = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumCh-1:0]     pins_i,
  input  logic [DebounceW-1:0] debounce_limit_i,
  input  logic [NumCh-1:0]     clear_i,
  output logic [NumCh-1:0]     inputs_o,
  output logic [NumCh-1:0]     rise_o,
  output logic [NumCh-1:0]     fall_o,
  output logic [NumCh-1:0]     pending_o
`ifdef SONATA_INPUT_IRQ_EN
  ,
  input  logic [NumCh-1:0]     irq_en_i,
  output logic                 irq_o
`endif
);

  // Synchroniser chain; flops idle at InvertMask so the corrected idle level is 0.
  logic [NumCh-1:0] r_sync [SyncStages];
  logic [NumCh-1:0] w_s;
  logic [NumCh-1:0] w_level;
  logic [NumCh-1:0] w_rise;
  logic [NumCh-1:0] w_fall;
  logic [NumCh-1:0] r_pending;

  // First synchroniser stage samples the asynchronous pins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync[0] <= InvertMask;
    end else begin
      r_sync[0] <= pins_i;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SyncStages; gi++) begin : g_sync
      // Further synchroniser stages for metastability settling.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_sync[gi] <= InvertMask;
        end else begin
          r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  // Polarity-corrected synchronised level: 1 means the input is "on".
  assign w_s = r_sync[SyncStages-1] ^ InvertMask;

  generate
    for (gi = 0; gi < NumCh; gi++) begin : g_ch
      logic [DebounceW-1:0] r_cnt;
      logic                 r_level;
      logic                 r_rise;
      logic                 r_fall;

      // Debounce: a differing level must persist past the limit before it is accepted.
      // The >= compare keeps the counter bounded and lets a lowered limit take effect
      // on the very next cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (w_s[gi] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt >= debounce_limit_i) begin
            r_level <= w_s[gi];
            r_cnt   <= '0;
            r_rise  <= w_s[gi];
            r_fall  <= ~w_s[gi];
          end else begin
            r_cnt <= r_cnt + DebounceW'(1);
          end
        end
      end

      assign w_level[gi] = r_level;
      assign w_rise[gi]  = r_rise;
      assign w_fall[gi]  = r_fall;
    end
  endgenerate

  // Sticky edge flags; a new edge wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~clear_i) | w_rise | w_fall;
    end
  end

  assign inputs_o  = w_level;
  assign rise_o    = w_rise;
  assign fall_o    = w_fall;
  assign pending_o = r_pending;

`ifdef SONATA_INPUT_IRQ_EN
  logic r_irq;

  // Registered level interrupt from enabled pending flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_pending & irq_en_i);
    end
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: tb/tb_sonata_input_conditioner.sv
// Testbench for sonata_input_conditioner: expected output values are pushed to a
// cycle-stamped scoreboard when stimulus is driven and compared on the falling edge.
module tb_sonata_input_conditioner;

  localparam int NumCh = 16;
  localparam int DW    = 20;

  localparam int F_IN   = 0;
  localparam int F_RISE = 1;
  localparam int F_FALL = 2;
  localparam int F_PEND = 3;
  localparam int F_EDGE = 4;
  localparam int F_IRQ  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NumCh-1:0] pins;
  logic [DW-1:0]    limit;
  logic [NumCh-1:0] clear;
  logic [NumCh-1:0] inputs;
  logic [NumCh-1:0] rise;
  logic [NumCh-1:0] fall;
  logic [NumCh-1:0] pending;
`ifdef SONATA_INPUT_IRQ_EN
  logic [NumCh-1:0] irq_en;
  logic             irq;
`endif

  sonata_input_conditioner #(
    .NumCh      (NumCh),
    .SyncStages (2),
    .DebounceW  (DW),
    .InvertMask ('1)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pins_i           (pins),
    .debounce_limit_i (limit),
    .clear_i          (clear),
    .inputs_o         (inputs),
    .rise_o           (rise),
    .fall_o           (fall),
    .pending_o        (pending)
`ifdef SONATA_INPUT_IRQ_EN
    ,
    .irq_en_i         (irq_en),
    .irq_o            (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          field;
    logic [15:0] exp;
    string       tag;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic sb_push(input int due, input int field, input logic [15:0] exp, input string tag);
    sb_item_t it;
    int idx;
    it.due   = due;
    it.field = field;
    it.exp   = exp;
    it.tag   = tag;
    idx = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].due > due) begin
        idx = k;
        break;
      end
    end
    sb.insert(idx, it);
  endtask

  function automatic logic [15:0] observe(input int field);
    logic [15:0] v;
    v = 16'h0;
    case (field)
      F_IN:   v = inputs;
      F_RISE: v = rise;
      F_FALL: v = fall;
      F_PEND: v = pending;
      F_EDGE: v = rise | fall;
`ifdef SONATA_INPUT_IRQ_EN
      F_IRQ:  v = {15'h0, irq};
`endif
      default: v = 16'hdead;
    endcase
    return v;
  endfunction

  // Compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_item_t it;
      it = sb.pop_front();
      $display("cycle %0d: check %s", cyc, it.tag);
      if (it.due < cyc) check_val({it.tag, "_missed"}, cyc, it.due);
      else check_val(it.tag, {16'h0, observe(it.field)}, {16'h0, it.exp});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int c1;
    int w;
    pins  = 16'hFFFF;
    limit = '0;
    clear = '0;
`ifdef SONATA_INPUT_IRQ_EN
    irq_en = 16'h0004;
`endif

    // Reset state, checked while reset is held and after release with idle pins.
    step(3);
    c = cyc;
    sb_push(c + 1, F_IN,   16'h0000, "rst_hold_inputs");
    sb_push(c + 1, F_PEND, 16'h0000, "rst_hold_pending");
    step(2);
    rst = 1'b0;
    c = cyc;
    sb_push(c + 1, F_IN,   16'h0000, "rel_inputs_a");
    sb_push(c + 4, F_IN,   16'h0000, "rel_inputs_b");
    sb_push(c + 4, F_EDGE, 16'h0000, "rel_no_pulse");
    sb_push(c + 4, F_PEND, 16'h0000, "rel_pending");
    step(6);

    // limit 4, ch0 pressed: output at +7, one-cycle rise, pending at +8.
    limit = DW'(4);
    c = cyc;
    pins[0] = 1'b0;
    sb_push(c + 6, F_IN,   16'h0000, "ch0_before");
    sb_push(c + 7, F_IN,   16'h0001, "ch0_on");
    sb_push(c + 7, F_RISE, 16'h0001, "ch0_rise");
    sb_push(c + 7, F_FALL, 16'h0000, "ch0_nofall");
    sb_push(c + 7, F_PEND, 16'h0000, "ch0_pend_late");
    sb_push(c + 8, F_RISE, 16'h0000, "ch0_rise_end");
    sb_push(c + 8, F_PEND, 16'h0001, "ch0_pend");
    step(12);

    // limit 10, 5-cycle glitch on ch3 is rejected.
    limit = DW'(10);
    c = cyc;
    for (int k = 2; k <= 22; k += 4) begin
      sb_push(c + k, F_IN,   16'h0001, "glitch_inputs");
      sb_push(c + k, F_EDGE, 16'h0000, "glitch_edges");
      sb_push(c + k, F_PEND, 16'h0001, "glitch_pend");
    end
    pins[3] = 1'b0;
    step(5);
    pins[3] = 1'b1;
    step(20);

    // ch1 press then release; fall coincides with clear, then a lone clear.
    limit = DW'(2);
    c = cyc;
    pins[1] = 1'b0;
    sb_push(c + 4, F_IN,   16'h0001, "ch1_before");
    sb_push(c + 5, F_IN,   16'h0003, "ch1_on");
    sb_push(c + 5, F_RISE, 16'h0002, "ch1_rise");
    sb_push(c + 6, F_PEND, 16'h0003, "ch1_pend");
    step(8);
    c1 = cyc;
    pins[1] = 1'b1;
    sb_push(c1 + 4, F_IN,   16'h0003, "ch1_still_on");
    sb_push(c1 + 5, F_IN,   16'h0001, "ch1_off");
    sb_push(c1 + 5, F_FALL, 16'h0002, "ch1_fall");
    sb_push(c1 + 5, F_RISE, 16'h0000, "ch1_norise");
    sb_push(c1 + 6, F_FALL, 16'h0000, "ch1_fall_end");
    sb_push(c1 + 6, F_PEND, 16'h0003, "set_wins");
    sb_push(c1 + 8, F_PEND, 16'h0003, "pend_held");
    sb_push(c1 + 9, F_PEND, 16'h0001, "lone_clear");
    step(5);
    clear = 16'h0002;
    step(1);
    clear = 16'h0000;
    step(2);
    clear = 16'h0012;
    step(1);
    clear = 16'h0000;
    step(3);

    // limit 1000 lowered to 3 once ch2 counter reaches 50: flips next cycle.
    limit = DW'(1000);
    c = cyc;
    pins[2] = 1'b0;
    sb_push(c + 52, F_IN,   16'h0001, "lower_before");
    sb_push(c + 53, F_IN,   16'h0005, "lower_flip");
    sb_push(c + 53, F_RISE, 16'h0004, "lower_rise");
    step(52);
    limit = DW'(3);
    step(4);

    // Clear everything, then ch2 release and ch5 press with limit 0.
    c = cyc;
    sb_push(c + 1, F_PEND, 16'h0000, "clear_all");
    clear = 16'hFFFF;
    step(1);
    clear = 16'h0000;
    step(2);
    limit = '0;
    c = cyc;
    pins[2] = 1'b1;
    sb_push(c + 2, F_IN,   16'h0005, "lim0_before");
    sb_push(c + 3, F_IN,   16'h0001, "lim0_ch2_off");
    sb_push(c + 3, F_FALL, 16'h0004, "lim0_ch2_fall");
    sb_push(c + 4, F_PEND, 16'h0004, "ch2_pend");
`ifdef SONATA_INPUT_IRQ_EN
    sb_push(c + 4, F_IRQ,  16'h0000, "irq_low");
    sb_push(c + 5, F_IRQ,  16'h0001, "irq_high");
    sb_push(c + 11, F_IRQ, 16'h0001, "irq_hold");
    sb_push(c + 13, F_IRQ, 16'h0001, "irq_clear_lag");
    sb_push(c + 14, F_IRQ, 16'h0000, "irq_cleared");
    sb_push(c + 15, F_IRQ, 16'h0000, "irq_masked_ch5");
`endif
    step(6);
    pins[5] = 1'b0;
    sb_push(c + 9,  F_IN,   16'h0021, "ch5_on");
    sb_push(c + 9,  F_RISE, 16'h0020, "ch5_rise");
    sb_push(c + 10, F_PEND, 16'h0024, "ch5_pend");
    step(6);
    clear = 16'h0004;
    sb_push(c + 13, F_PEND, 16'h0020, "ch2_cleared");
    step(1);
    clear = 16'h0000;
    step(4);

    // Reset mid-debounce on ch6: state discarded, no pulse on release.
    limit = DW'(10);
    pins[6] = 1'b0;
    step(6);
    rst = 1'b1;
    pins[6] = 1'b1;
    c = cyc;
    sb_push(c + 1, F_IN,   16'h0000, "mid_rst_inputs");
    sb_push(c + 1, F_PEND, 16'h0000, "mid_rst_pend");
    sb_push(c + 1, F_EDGE, 16'h0000, "mid_rst_edges");
    step(2);
    rst = 1'b0;
    c = cyc;
    sb_push(c + 1,  F_EDGE, 16'h0000, "rel_edge_a");
    sb_push(c + 2,  F_EDGE, 16'h0000, "rel_edge_b");
    sb_push(c + 12, F_IN,   16'h0000, "rel_before");
    sb_push(c + 13, F_IN,   16'h0021, "rel_resync");
    sb_push(c + 13, F_RISE, 16'h0021, "rel_rise");
    sb_push(c + 13, F_FALL, 16'h0000, "rel_nofall");
    sb_push(c + 14, F_PEND, 16'h0021, "rel_pend");
    step(16);

    w = 0;
    while (sb.size() > 0 && w < 100) begin
      step(1);
      w++;
    end
    check_val("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
